// File: rtl/button_events.sv
// button_events: N-channel push-button front end.
// Each raw button input is synchronised and debounced, then tracked by a small
// hold state machine. All outputs are registered in the clk domain.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low (0 = in reset)
//   in            raw button levels, asynchronous, 1 = pressed
//   level         debounced button state
//   press         1-cycle pulse on accepted 0->1 of level
//   release_pulse 1-cycle pulse on accepted 1->0 of level
//   long_press    1-cycle pulse once the button has been held LONG_CYCLES
//   repeat_pulse  1-cycle pulse every REPEAT_CYCLES after long_press while held
//   any_press     OR of press, in the same cycle as press
//
// "release" and "repeat" are SystemVerilog keywords and cannot be used as
// port names, so those two outputs carry a _pulse suffix.
//
// Channel FSM:
//   state | meaning
//   IDLE  | level is 0, waiting for an accepted rise
//   HELD  | pressed, hcnt counting towards long_press
//   LONG  | long_press issued, hcnt counting repeat periods
module button_events #(
    parameter int N               = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 20,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_press,
    output logic [N-1:0] repeat_pulse,
    output logic         any_press
);

    localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DW-1:0] D_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = (REPEAT_CYCLES > 0) ? HW'(REPEAT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    logic [N-1:0] press_nv;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sff;
        logic                   s;
        logic                   mismatch;
        logic                   flip;
        logic                   rise;
        logic                   fall;
        logic [DW-1:0]          dcnt;
        logic                   lvl;
        state_t                 st, st_n;
        logic [HW-1:0]          hcnt, hcnt_n;
        logic                   press_n, rel_n, long_n, rep_n;
        logic                   press_q, rel_q, long_q, rep_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sff <= '0;
            end else begin
                sff <= {sff[SYNC_STAGES-2:0], in[i]};
            end
        end

        assign s        = sff[SYNC_STAGES-1];
        assign mismatch = (s != lvl);
        // The edge that sees the DEBOUNCE_CYCLES-th consecutive mismatch flips level.
        assign flip     = mismatch && (dcnt == D_LAST);
        assign rise     = flip && !lvl;
        assign fall     = flip && lvl;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dcnt <= '0;
                lvl  <= 1'b0;
            end else if (!mismatch) begin
                dcnt <= '0;
            end else if (flip) begin
                dcnt <= '0;
                lvl  <= ~lvl;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st      <= IDLE;
                hcnt    <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                st      <= st_n;
                hcnt    <= hcnt_n;
                press_q <= press_n;
                rel_q   <= rel_n;
                long_q  <= long_n;
                rep_q   <= rep_n;
            end
        end

        always_comb begin
            st_n    = st;
            hcnt_n  = hcnt;
            press_n = 1'b0;
            rel_n   = 1'b0;
            long_n  = 1'b0;
            rep_n   = 1'b0;
            // A fall takes priority, so a long/repeat due on the same edge is dropped.
            if (fall) begin
                st_n   = IDLE;
                hcnt_n = '0;
                rel_n  = 1'b1;
            end else begin
                case (st)
                    IDLE: begin
                        if (rise) begin
                            st_n    = HELD;
                            hcnt_n  = '0;
                            press_n = 1'b1;
                        end
                    end
                    HELD: begin
                        if (hcnt == LONG_LAST) begin
                            st_n   = LONG;
                            hcnt_n = '0;
                            long_n = 1'b1;
                        end else begin
                            hcnt_n = hcnt + 1'b1;
                        end
                    end
                    LONG: begin
                        if (REPEAT_CYCLES > 0) begin
                            if (hcnt == REP_LAST) begin
                                hcnt_n = '0;
                                rep_n  = 1'b1;
                            end else begin
                                hcnt_n = hcnt + 1'b1;
                            end
                        end else begin
                            hcnt_n = '0;
                        end
                    end
                    default: begin
                        st_n   = IDLE;
                        hcnt_n = '0;
                    end
                endcase
            end
        end

        assign press_nv[i]      = press_n;
        assign level[i]         = lvl;
        assign press[i]         = press_q;
        assign release_pulse[i] = rel_q;
        assign long_press[i]    = long_q;
        assign repeat_pulse[i]  = rep_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_nv;
        end
    end

endmodule

// File: tb/tb_button_events.sv
module tb_button_events;

    logic       clk;
    logic       reset;
    logic [3:0] in;
    logic [3:0] level, press, release_pulse, long_press, repeat_pulse;
    logic       any_press;

    logic [0:0] in_b;
    logic [0:0] level_b, press_b, rel_b, long_b, rep_b;
    logic       any_b;

    int checks   = 0;
    int failures = 0;

    button_events #(
        .N(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .in(in),
        .level(level), .press(press), .release_pulse(release_pulse),
        .long_press(long_press), .repeat_pulse(repeat_pulse), .any_press(any_press)
    );

    button_events #(
        .N(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(0)
    ) dut_norep (
        .clk(clk), .reset(reset), .in(in_b),
        .level(level_b), .press(press_b), .release_pulse(rel_b),
        .long_press(long_b), .repeat_pulse(rep_b), .any_press(any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in    = '0;
        in_b  = '0;
        #3;
        checks++;
        if ({level, press, release_pulse, long_press, repeat_pulse, any_press} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {level, press, release_pulse, long_press, repeat_pulse, any_press});
        end
        checks++;
        if ({level_b, press_b, rel_b, long_b, rep_b, any_b} !== 6'd0) begin
            failures++;
            $display("FAIL reset_outputs_norep got=%h want=0",
                     {level_b, press_b, rel_b, long_b, rep_b, any_b});
        end
        step();
        step();
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if ({level, press, release_pulse, long_press, repeat_pulse, any_press} !== 21'd0) begin
                failures++;
                $display("FAIL idle_after_reset k=%0d got=%h want=0", k,
                         {level, press, release_pulse, long_press, repeat_pulse, any_press});
            end
        end
    endtask

    task automatic test_press();
        in[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (press !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL press0 k=%0d got=%b want=%b", k, press, (k == 6) ? 4'b0001 : 4'b0000);
            end
            checks++;
            if (any_press !== (k == 6)) begin
                failures++;
                $display("FAIL any_press0 k=%0d got=%b want=%b", k, any_press, (k == 6));
            end
            checks++;
            if (level[0] !== (k >= 6)) begin
                failures++;
                $display("FAIL level0 k=%0d got=%b want=%b", k, level[0], (k >= 6));
            end
        end
        in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (release_pulse !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL release0 k=%0d got=%b want=%b", k, release_pulse,
                         (k == 6) ? 4'b0001 : 4'b0000);
            end
            checks++;
            if ({press, long_press, repeat_pulse} !== 12'd0) begin
                failures++;
                $display("FAIL quiet0 k=%0d got=%h want=0", k, {press, long_press, repeat_pulse});
            end
            checks++;
            if (level[0] !== (k < 6)) begin
                failures++;
                $display("FAIL level0_fall k=%0d got=%b want=%b", k, level[0], (k < 6));
            end
        end
    endtask

    task automatic test_bounce();
        logic [11:0] pat;
        pat = 12'b111_000_111_000;
        for (int k = 1; k <= 22; k++) begin
            in[1] = (k <= 12) ? pat[12 - k] : 1'b0;
            step();
            checks++;
            if ({press[1], release_pulse[1], level[1]} !== 3'b000) begin
                failures++;
                $display("FAIL bounce1 k=%0d got=%b want=000", k,
                         {press[1], release_pulse[1], level[1]});
            end
        end
    endtask

    task automatic test_long_repeat();
        logic exp_p, exp_l, exp_r, exp_rel;
        in[2] = 1'b1;
        for (int k = 1; k <= 86; k++) begin
            step();
            exp_p   = (k == 6);
            exp_l   = (k == 26);
            exp_r   = (k == 34) || (k == 42) || (k == 50) || (k == 58);
            exp_rel = (k == 66);
            checks++;
            if ({press[2], long_press[2], repeat_pulse[2], release_pulse[2]} !==
                {exp_p, exp_l, exp_r, exp_rel}) begin
                failures++;
                $display("FAIL long2 k=%0d got p/l/r/rel=%b want=%b", k,
                         {press[2], long_press[2], repeat_pulse[2], release_pulse[2]},
                         {exp_p, exp_l, exp_r, exp_rel});
            end
            if (k == 60) in[2] = 1'b0;
        end
    endtask

    task automatic test_no_repeat();
        in_b[0] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            checks++;
            if ({press_b[0], long_b[0], rep_b[0], rel_b[0]} !==
                {(k == 6), (k == 26), 1'b0, (k == 56)}) begin
                failures++;
                $display("FAIL norep k=%0d got p/l/r/rel=%b want=%b", k,
                         {press_b[0], long_b[0], rep_b[0], rel_b[0]},
                         {(k == 6), (k == 26), 1'b0, (k == 56)});
            end
            if (k == 50) in_b[0] = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        in = 4'b1001;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (press !== ((k == 6) ? 4'b1001 : 4'b0000)) begin
                failures++;
                $display("FAIL simul_press k=%0d got=%b want=%b", k, press,
                         (k == 6) ? 4'b1001 : 4'b0000);
            end
            checks++;
            if (any_press !== (k == 6)) begin
                failures++;
                $display("FAIL simul_any k=%0d got=%b want=%b", k, any_press, (k == 6));
            end
        end
        in = 4'b0000;
        for (int k = 1; k <= 10; k++) step();
        checks++;
        if (level !== 4'b0000) begin
            failures++;
            $display("FAIL simul_level_after got=%b want=0000", level);
        end
    endtask

    task automatic test_reset_mid_hold();
        in[1] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 26) begin
                checks++;
                if (long_press[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL midhold_long got=%b want=1", long_press[1]);
                end
            end
        end
        checks++;
        if (level[1] !== 1'b1) begin
            failures++;
            $display("FAIL midhold_level got=%b want=1", level[1]);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({level, press, release_pulse, long_press, repeat_pulse, any_press} !== 21'd0) begin
            failures++;
            $display("FAIL midhold_async got=%h want=0",
                     {level, press, release_pulse, long_press, repeat_pulse, any_press});
        end
        step();
        step();
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if ({press[1], release_pulse[1], level[1]} !== {(k == 6), 1'b0, (k >= 6)}) begin
                failures++;
                $display("FAIL midhold_repress k=%0d got p/rel/lvl=%b want=%b", k,
                         {press[1], release_pulse[1], level[1]}, {(k == 6), 1'b0, (k >= 6)});
            end
        end
        in[1] = 1'b0;
        for (int k = 1; k <= 10; k++) step();
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_long_repeat();
        test_no_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Parametrised, multi-channel successor to the single-button press detector.
- Each of N raw, asynchronous button inputs is synchronised, debounced and run through a per-channel hold state machine.
- Per channel it produces a debounced level plus one-cycle pulses for press, release, long-press and auto-repeat.
- Sits between board push-button pins and the UI/control logic; all outputs are in the clk domain.

Parameters:
- N, 4, number of independent button channels (>=1).
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised level must differ from the stable level before it is accepted (>=1).
- LONG_CYCLES, 20, cycles after the press pulse before long_press fires (>DEBOUNCE_CYCLES).
- REPEAT_CYCLES, 8, auto-repeat period after long_press; 0 disables repeat.

Ports:
- clk, input, 1, system clock; all state on the rising edge.
- reset, input, 1, asynchronous, active-low (0 = in reset); clears all state immediately.
- in, input, N, raw button levels, asynchronous, 1 = pressed.
- level, output, N, debounced button state.
- press, output, N, 1-cycle pulse on accepted 0->1 of level.
- release, output, N, 1-cycle pulse on accepted 1->0 of level.
- long_press, output, N, 1-cycle pulse when held LONG_CYCLES.
- repeat, output, N, 1-cycle pulse every REPEAT_CYCLES after long_press while held.
- any_press, output, 1, OR of press[N-1:0] (registered, same cycle as press).

Behaviour:
- Reset (reset=0, async): synchronisers, counters, level, press, release, long_press, repeat and any_press go to 0; every channel FSM goes to IDLE.
- Synchroniser: s[i] = in[i] delayed SYNC_STAGES edges. No combinational path from in to any output.
- Debounce, per channel:
  - dcnt clears to 0 on every edge where s == level.
  - On each edge where s != level, dcnt increments.
  - On the edge where the mismatch count reaches DEBOUNCE_CYCLES, level flips, dcnt clears and press or release is registered high for exactly one cycle.
  - A mismatch run shorter than DEBOUNCE_CYCLES causes no event.
- Latency: in rising before edge 1, stable thereafter -> press high during the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES. Release latency is identical.
- Channel FSM:
  - IDLE: level=0. Accepted rise -> HELD; hcnt=0; press=1.
  - HELD: hcnt increments each edge. When hcnt reaches LONG_CYCLES-1 -> LONG; long_press=1; hcnt=0.
  - LONG: if REPEAT_CYCLES>0, hcnt increments each edge; when hcnt reaches REPEAT_CYCLES-1, repeat=1 and hcnt wraps to 0. If REPEAT_CYCLES=0, hcnt holds at 0 and repeat never asserts.
  - Any state, accepted fall -> IDLE; release=1; hcnt=0; no further long_press or repeat.
- Timing of long events: long_press fires LONG_CYCLES cycles after the press pulse. Repeats fire at LONG_CYCLES+k*REPEAT_CYCLES, k>=1.
- Simultaneous events:
  - Release and a due long_press/repeat on the same edge: release wins; the due long_press/repeat is suppressed.
  - press and release for one channel can never assert together.
  - Channels are fully independent; multiple channels may pulse in the same cycle.
- Counter widths: $clog2(max+1) of the relevant parameter. No overflow possible; hcnt wraps only as specified.
- Reset mid-hold:
  - All outputs drop asynchronously.
  - No release pulse is generated for the interrupted hold.
  - If in is still high after reset deasserts, a fresh press follows after SYNC_STAGES+DEBOUNCE_CYCLES edges.
- in held constant from reset produces no events except as above.

Test Plan:
- Defaults, in[0] rises and holds 10 cycles -> press[0] pulses one cycle, SYNC_STAGES+DEBOUNCE_CYCLES=6 edges after the first sampling edge; level[0]=1; any_press=1 in the same cycle.
- Bounce: in[1] toggles 1,0,1,0 with pulses of 3 cycles each, then stays 0 -> no press/release; level[1] stays 0.
- Hold in[2] for 60 cycles -> press at t, long_press at t+20, repeat at t+28, t+36, t+44, t+52, ...; release 6 cycles after in falls; no repeat after release.
- REPEAT_CYCLES=0, hold 50 cycles -> a single long_press, zero repeat pulses.
- Channels 0 and 3 pressed on the same cycle -> both press bits high together; any_press high one cycle.
- Assert reset during LONG with in held -> outputs 0 immediately; no release; after reset deasserts, press reappears after 6 edges.
